uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 14 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter:
// default geometry and the serializer state encoding.
package uart_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle: per-requester valid/data in, one-hot ready out.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the slot after the
// last grant, wrapping, and returns a one-hot grant plus its encoded index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int unsigned cand;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (en && !found && req[IDX_W'(cand)]) begin
                grant[IDX_W'(cand)] = 1'b1;
                idx                 = IDX_W'(cand);
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shared 8N1-style serial transmitter: round-robin accepts one requester's byte
// in IDLE, then shifts start/data/stop bits out on successive bit_tick strobes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_tick,
    uart_tx_arbiter_if.slave           req,
    output logic                       tx,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             state;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  grant_data;
    logic [NUM_REQ-1:0] grant;
    logic               grant_en;

    // Grants only from IDLE and never while reset is asserted, so ready can't leak.
    assign grant_en = (state == IDLE) && !reset;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req.req_valid),
        .last  (last_idx),
        .en    (grant_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign req.req_ready = grant;

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_data = req.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            last_idx <= IDX_W'(NUM_REQ - 1);
            cur_idx  <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A tick coinciding with the grant is deliberately not consumed here.
                    if (|grant) begin
                        data_q   <= grant_data;
                        cur_idx  <= grant_idx;
                        last_idx <= grant_idx;
                        busy     <= 1'b1;
                        state    <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (bit_tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx      <= data_q[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == BIT_W'(DATA_W - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= data_q[bit_idx + 1'b1];
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        done_id <= cur_idx;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a frame-level
// reference model (round-robin pick order and start/LSB-first/stop bit list).
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          bit_tick;
    logic          tx;
    logic          busy;
    logic          done;
    logic [IW-1:0] done_id;

    int checks    = 0;
    int errors    = 0;
    int last_model;
    int ready_log[$];
    int ready_bad = 0;
    int done_cnt  = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) ifc ();

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_tick (bit_tick),
        .req      (ifc),
        .tx       (tx),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id)
    );

    always #5 clk = ~clk;

    // Records every ready pulse (one entry per cycle high) and every done pulse.
    always @(negedge clk) begin
        if (|ifc.req_ready) begin
            if ($countones(ifc.req_ready) != 1 || busy) ready_bad++;
            for (int i = NR - 1; i >= 0; i--) begin
                if (ifc.req_ready[i]) begin
                    ready_log.push_back(i);
                    i = -1;
                end
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int off = 1; off <= NR; off++) begin
            if (v[(last + off) % NR]) return (last + off) % NR;
        end
        return -1;
    endfunction

    function automatic logic [DW+1:0] frame_bits(input logic [DW-1:0] b);
        logic [DW+1:0] f;
        f = '0;
        for (int i = 0; i < DW; i++) f[i+1] = (((b >> i) & 1) != 0);
        f[DW+1] = 1'b1;
        return f;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_after(input int period);
        repeat (period - 1) cyc();
        bit_tick = 1'b1;
        cyc();
        bit_tick = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bit_tick = 1'b0;
        ifc.req_valid = '0;
        cyc();
        cyc();
        reset = 1'b0;
        last_model = NR - 1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] b);
        ifc.req_data[i*DW +: DW] = b;
    endtask

    task automatic wait_grant(output int gid);
        gid = -1;
        for (int n = 0; n < 64 && gid < 0; n++) begin
            #2;
            if (|ifc.req_ready) begin
                for (int i = 0; i < NR; i++) if (ifc.req_ready[i]) gid = i;
                cyc();
                ifc.req_valid[gid] = 1'b0;
            end else begin
                cyc();
            end
        end
    endtask

    task automatic run_frame(input int period, output logic [DW+1:0] seq, output int glitches,
                             output logic got_done, output logic [IW-1:0] did);
        logic prev;
        prev = tx;
        glitches = 0;
        seq = '0;
        got_done = 1'b0;
        did = '0;
        for (int t = 0; t < DW + 3; t++) begin
            for (int c = 0; c < period - 1; c++) begin
                cyc();
                if (tx !== prev) glitches++;
            end
            bit_tick = 1'b1;
            cyc();
            bit_tick = 1'b0;
            if (t < DW + 2) seq[t] = tx;
            else begin
                got_done = done;
                did = done_id;
            end
            prev = tx;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bit_tick = 1'b1;
        ifc.req_valid = '1;
        ifc.req_data = {$urandom, $urandom};
        cyc();
        cyc();
        #2;
        checks++; if (ifc.req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ifc.req_ready); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (done_id !== '0) begin errors++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
        reset = 1'b0;
        bit_tick = 1'b0;
        ifc.req_valid = '0;
        last_model = NR - 1;
        cyc();
    endtask

    task automatic test_single();
        int gid, exp_id, gl, d0;
        logic [DW+1:0] seq;
        logic gd;
        logic [IW-1:0] did;
        set_data(0, 8'hA5);
        ifc.req_valid = 4'b0001;
        exp_id = rr_pick(4'b0001, last_model);
        wait_grant(gid);
        last_model = exp_id;
        checks++; if (gid != exp_id) begin errors++; $display("FAIL single_grant: got %0d expected %0d", gid, exp_id); end
        d0 = done_cnt;
        run_frame(16, seq, gl, gd, did);
        checks++; if (seq !== frame_bits(8'hA5)) begin errors++; $display("FAIL single_tx_seq: got %b expected %b", seq, frame_bits(8'hA5)); end
        checks++; if (gl != 0) begin errors++; $display("FAIL single_tx_stable: got %0d changes expected 0", gl); end
        checks++; if (gd !== 1'b1 || did !== IW'(exp_id)) begin errors++; $display("FAIL single_done: got done=%b id=%0d expected done=1 id=%0d", gd, did, exp_id); end
        cyc();
        checks++; if (done !== 1'b0 || done_cnt != d0 + 1) begin errors++; $display("FAIL single_done_pulse: got done=%b count=%0d expected 0 and %0d", done, done_cnt - d0, 1); end
    endtask

    task automatic test_all_requesters();
        int gid, exp_id, gl, rl0, per;
        int exp_order[$];
        logic [DW-1:0] bytes[NR];
        logic [DW-1:0] b;
        logic [DW+1:0] seq;
        logic gd;
        logic [IW-1:0] did;
        apply_reset();
        for (int i = 0; i < NR; i++) begin bytes[i] = DW'($urandom); set_data(i, bytes[i]); end
        ifc.req_valid = '1;
        rl0 = ready_log.size();
        for (int f = 0; f < 5; f++) begin
            exp_id = rr_pick(ifc.req_valid, last_model);
            exp_order.push_back(exp_id);
            wait_grant(gid);
            checks++; if (gid != exp_id) begin errors++; $display("FAIL all_grant_%0d: got %0d expected %0d", f, gid, exp_id); end
            last_model = exp_id;
            b = bytes[exp_id];
            if (f < 4) begin
                bytes[exp_id] = DW'($urandom);
                set_data(exp_id, bytes[exp_id]);
                ifc.req_valid[exp_id] = 1'b1;
            end else begin
                ifc.req_valid = '0;
            end
            per = $urandom_range(2, 8);
            run_frame(per, seq, gl, gd, did);
            checks++; if (seq !== frame_bits(b) || gl != 0) begin errors++; $display("FAIL all_tx_%0d: got %b (%0d changes) expected %b", f, seq, gl, frame_bits(b)); end
            checks++; if (gd !== 1'b1 || did !== IW'(exp_id)) begin errors++; $display("FAIL all_done_%0d: got done=%b id=%0d expected done=1 id=%0d", f, gd, did, exp_id); end
        end
        checks++; if (ready_log.size() - rl0 != 5) begin errors++; $display("FAIL all_ready_pulses: got %0d expected 5", ready_log.size() - rl0); end
        for (int k = 0; k < 5 && rl0 + k < ready_log.size(); k++) begin
            checks++; if (ready_log[rl0 + k] != exp_order[k]) begin errors++; $display("FAIL all_ready_order_%0d: got %0d expected %0d", k, ready_log[rl0 + k], exp_order[k]); end
        end
    endtask

    task automatic test_tick_in_grant();
        int r, per, bad1, bad2;
        logic [DW-1:0] b;
        logic [NR-1:0] v;
        r = rr_pick(NR'(1 << $urandom_range(0, NR - 1)), last_model);
        v = '0;
        v[r] = 1'b1;
        b = DW'($urandom);
        set_data(r, b);
        ifc.req_valid = v;
        bit_tick = 1'b1;
        #2;
        checks++; if (ifc.req_ready !== v) begin errors++; $display("FAIL tig_ready: got %b expected %b", ifc.req_ready, v); end
        cyc();
        bit_tick = 1'b0;
        ifc.req_valid = '0;
        last_model = r;
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL tig_after_grant: got tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
        per = $urandom_range(4, 10);
        bad1 = 0;
        for (int c = 0; c < per - 1; c++) begin cyc(); if (tx !== 1'b1) bad1++; end
        bit_tick = 1'b1; cyc(); bit_tick = 1'b0;
        checks++; if (bad1 != 0 || tx !== 1'b0) begin errors++; $display("FAIL tig_start_edge: got tx=%b early=%0d expected tx=0 early=0", tx, bad1); end
        bad2 = 0;
        for (int c = 0; c < per - 1; c++) begin cyc(); if (tx !== 1'b0) bad2++; end
        bit_tick = 1'b1; cyc(); bit_tick = 1'b0;
        checks++; if (bad2 != 0 || tx !== b[0]) begin errors++; $display("FAIL tig_start_len: got tx=%b short=%0d expected tx=%b short=0", tx, bad2, b[0]); end
        for (int t = 0; t < DW + 1; t++) tick_after(per);
        checks++; if (done !== 1'b1 || done_id !== IW'(r)) begin errors++; $display("FAIL tig_done: got done=%b id=%0d expected done=1 id=%0d", done, done_id, r); end
    endtask

    task automatic test_reset_mid_frame();
        int r, gid, per, d0, rl0;
        logic [DW-1:0] b;
        r = $urandom_range(0, NR - 1);
        b = DW'($urandom) & ~DW'(8'h08);
        set_data(r, b);
        ifc.req_valid = '0;
        ifc.req_valid[r] = 1'b1;
        wait_grant(gid);
        checks++; if (gid != rr_pick(NR'(1 << r), last_model)) begin errors++; $display("FAIL rmf_grant: got %0d expected %0d", gid, r); end
        per = $urandom_range(3, 8);
        for (int t = 0; t < 5; t++) tick_after(per);
        checks++; if (tx !== b[3] || busy !== 1'b1) begin errors++; $display("FAIL rmf_bit3: got tx=%b busy=%b expected tx=%b busy=1", tx, busy, b[3]); end
        d0 = done_cnt;
        rl0 = ready_log.size();
        cyc();
        reset = 1'b1;
        bit_tick = 1'b1;
        cyc();
        reset = 1'b0;
        bit_tick = 1'b0;
        last_model = NR - 1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmf_abort: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
        for (int t = 0; t < DW + 4; t++) tick_after(per);
        checks++; if (done_cnt != d0 || ready_log.size() != rl0) begin errors++; $display("FAIL rmf_no_done: got done=%0d grants=%0d expected 0 and 0", done_cnt - d0, ready_log.size() - rl0); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmf_idle_tx: got %b expected 1", tx); end
    endtask

    task automatic test_skip_slot();
        int gid, exp_id, gl;
        logic [DW-1:0] b0, b3;
        logic [DW+1:0] seq;
        logic gd;
        logic [IW-1:0] did;
        apply_reset();
        set_data(1, DW'($urandom));
        ifc.req_valid = 4'b0010;
        wait_grant(gid);
        checks++; if (gid != 1) begin errors++; $display("FAIL skip_first: got %0d expected 1", gid); end
        last_model = 1;
        run_frame(3, seq, gl, gd, did);
        b0 = DW'($urandom);
        b3 = DW'($urandom);
        set_data(0, b0);
        set_data(3, b3);
        ifc.req_valid = 4'b1001;
        exp_id = rr_pick(4'b1001, last_model);
        wait_grant(gid);
        checks++; if (gid != exp_id) begin errors++; $display("FAIL skip_grant3: got %0d expected %0d", gid, exp_id); end
        last_model = exp_id;
        set_data(2, DW'($urandom));
        run_frame(4, seq, gl, gd, did);
        checks++; if (seq !== frame_bits(b3) || did !== IW'(exp_id)) begin errors++; $display("FAIL skip_frame3: got %b id=%0d expected %b id=%0d", seq, did, frame_bits(b3), exp_id); end
        exp_id = rr_pick(ifc.req_valid, last_model);
        wait_grant(gid);
        checks++; if (gid != exp_id) begin errors++; $display("FAIL skip_grant0: got %0d expected %0d", gid, exp_id); end
        last_model = exp_id;
        run_frame(4, seq, gl, gd, did);
        checks++; if (seq !== frame_bits(b0) || did !== IW'(exp_id)) begin errors++; $display("FAIL skip_frame0: got %b id=%0d expected %b id=%0d", seq, did, frame_bits(b0), exp_id); end
    endtask

    task automatic test_stall();
        int r, gid, per, chg;
        logic [DW-1:0] b;
        r = $urandom_range(0, NR - 1);
        b = DW'($urandom);
        set_data(r, b);
        ifc.req_valid = '0;
        ifc.req_valid[r] = 1'b1;
        wait_grant(gid);
        checks++; if (gid != rr_pick(NR'(1 << r), last_model)) begin errors++; $display("FAIL stall_grant: got %0d expected %0d", gid, r); end
        last_model = r;
        per = $urandom_range(3, 8);
        for (int t = 0; t < 4; t++) tick_after(per);
        chg = 0;
        for (int c = 0; c < 100; c++) begin cyc(); if (tx !== b[2] || busy !== 1'b1) chg++; end
        checks++; if (chg != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", chg); end
        for (int k = 3; k < DW; k++) begin
            tick_after(per);
            checks++; if (tx !== b[k]) begin errors++; $display("FAIL stall_resume_bit%0d: got %b expected %b", k, tx, b[k]); end
        end
        tick_after(per);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL stall_stop: got %b expected 1", tx); end
        tick_after(per);
        checks++; if (done !== 1'b1 || done_id !== IW'(r)) begin errors++; $display("FAIL stall_done: got done=%b id=%0d expected done=1 id=%0d", done, done_id, r); end
    endtask

    task automatic test_random();
        int gid, exp_id, gl;
        logic [NR-1:0] p, newm;
        logic [DW-1:0] bytes[NR];
        logic [DW-1:0] b;
        logic [DW+1:0] seq;
        logic gd;
        logic [IW-1:0] did;
        p = '0;
        for (int it = 0; it < 8; it++) begin
            newm = NR'($urandom) & ~p;
            if (p == '0 && newm == '0) newm[$urandom_range(0, NR - 1)] = 1'b1;
            for (int i = 0; i < NR; i++) if (newm[i]) begin bytes[i] = DW'($urandom); set_data(i, bytes[i]); end
            p = p | newm;
            ifc.req_valid = p;
            exp_id = rr_pick(p, last_model);
            wait_grant(gid);
            checks++; if (gid != exp_id) begin errors++; $display("FAIL rand_grant_%0d: got %0d expected %0d", it, gid, exp_id); end
            p[exp_id] = 1'b0;
            last_model = exp_id;
            b = bytes[exp_id];
            ifc.req_valid = (it == 7) ? '0 : p;
            run_frame($urandom_range(1, 6), seq, gl, gd, did);
            checks++; if (seq !== frame_bits(b) || gl != 0) begin errors++; $display("FAIL rand_tx_%0d: got %b (%0d changes) expected %b", it, seq, gl, frame_bits(b)); end
            checks++; if (gd !== 1'b1 || did !== IW'(exp_id)) begin errors++; $display("FAIL rand_done_%0d: got done=%b id=%0d expected done=1 id=%0d", it, gd, did, exp_id); end
        end
    endtask

    initial begin
        reset = 1'b0;
        bit_tick = 1'b0;
        ifc.req_valid = '0;
        ifc.req_data = '0;
        last_model = NR - 1;
        test_reset();
        test_single();
        test_all_requesters();
        test_tick_in_grant();
        test_reset_mid_frame();
        test_skip_slot();
        test_stall();
        test_random();
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL ready_onehot_idle: got %0d bad pulses expected 0", ready_bad); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
